// File: rtl/opendrain_serial_tx.sv
// Open-drain serial transmitter: start, W data bits, stop on a wired-AND line.
// Watches the line during data 1-bits and backs off when another device wins.
module opendrain_serial_tx #(
  parameter int W         = 8,
  parameter int DIV_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic [W-1:0]     tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             arb_lost,
  output logic             line,
  inout  wire              pad
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_top;
  logic [BW-1:0]    r_bit;
  logic [W-1:0]     r_sh;
  logic             r_oe;
  logic             r_arb;
  logic             r_s1;
  logic             r_line;

  logic             w_pad_in;
  logic [DIV_W-1:0] w_top;
  logic             w_end;
  logic             w_cur;
  logic [W-1:0]     w_sh_n;
  logic             w_nxt;

  // Bit period is max(clkdiv,3)+1, so the count top is max(clkdiv,3).
  assign w_top  = (clkdiv < DIV_W'(3)) ? DIV_W'(3) : clkdiv;
  assign w_end  = (r_cnt == r_top);
  assign w_cur  = MSB_FIRST ? r_sh[W-1] : r_sh[0];
  assign w_sh_n = MSB_FIRST ? (r_sh << 1) : (r_sh >> 1);
  assign w_nxt  = MSB_FIRST ? w_sh_n[W-1] : w_sh_n[0];

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = ~tx_ready;
  assign arb_lost = r_arb;
  assign line     = r_line;

  // Pad buffer: data tied low, only the enable toggles (never drive a 1).
`ifdef FPGA_ICE40
  SB_IO #(
    .PIN_TYPE (6'b1010_01),
    .PULLUP   (1'b1)
  ) u_io (
    .PACKAGE_PIN   (pad),
    .OUTPUT_ENABLE (r_oe),
    .D_OUT_0       (1'b0),
    .D_IN_0        (w_pad_in)
  );
`elsif FPGA_ECP5
  (* PULLMODE = "UP" *)
  BB u_bb (
    .I (1'b0),
    .T (~r_oe),
    .O (w_pad_in),
    .B (pad)
  );
`else
  assign pad = r_oe ? 1'b0 : 1'bz;
  pullup (pad);
  assign w_pad_in = pad;
`endif

  // Two-flop synchroniser for the pad level; idles high like the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_line <= 1'b1;
    end else begin
      r_s1   <= w_pad_in;
      r_line <= r_s1;
    end
  end

  // Frame FSM with registered pad enable and arbitration pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_top   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_oe    <= 1'b0;
      r_arb   <= 1'b0;
    end else begin
      r_arb <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_sh    <= tx_data;
            r_top   <= w_top;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_oe    <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_end) begin
            r_cnt   <= '0;
            r_oe    <= ~w_cur;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_end) begin
            r_cnt <= '0;
            if (w_cur && !r_line) begin
              r_oe    <= 1'b0;
              r_arb   <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_bit == BW'(W-1)) begin
              r_oe    <= 1'b0;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_sh  <= w_sh_n;
              r_oe  <= ~w_nxt;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_end) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opendrain_serial_tx.sv
// Bench for opendrain_serial_tx: per-cycle pad scoreboard on MSB/LSB
// instances, arbitration loss, async reset and back-to-back frames.
module tb_opendrain_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] clkdiv = 8'd9;
  logic [7:0] tx_data = 8'h00;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic       rdy0, busy0, arb0, line0;
  logic       rdy1, busy1, arb1, line1;
  wire        pad0;
  wire        pad1;
  logic       tb_low = 1'b0;

  assign pad0 = tb_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  opendrain_serial_tx #(.W(8), .DIV_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clkdiv   (clkdiv),
    .tx_data  (tx_data),
    .tx_valid (v0),
    .tx_ready (rdy0),
    .busy     (busy0),
    .arb_lost (arb0),
    .line     (line0),
    .pad      (pad0)
  );

  opendrain_serial_tx #(.W(8), .DIV_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clkdiv   (clkdiv),
    .tx_data  (tx_data),
    .tx_valid (v1),
    .tx_ready (rdy1),
    .busy     (busy1),
    .arb_lost (arb1),
    .line     (line1),
    .pad      (pad1)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];
  logic arb_seen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pad_of(input int s);
    return s != 0 ? pad1 : pad0;
  endfunction

  function automatic logic rdy_of(input int s);
    return s != 0 ? rdy1 : rdy0;
  endfunction

  function automatic logic arb_of(input int s);
    return s != 0 ? arb1 : arb0;
  endfunction

  task automatic set_v(input int s, input logic v);
    if (s != 0) v1 = v;
    else v0 = v;
  endtask

  // Expected pad level per cycle: start, data bits, stop.
  task automatic push_frame(input logic [7:0] d, input int p, input bit msb);
    logic b;
    repeat (p) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b = msb ? d[7-i] : d[i];
      repeat (p) exp_q.push_back(b);
    end
    repeat (p) exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready(input int s);
    int k;
    k = 0;
    @(negedge clk);
    while (!rdy_of(s) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ready", 32'(rdy_of(s)), 32'd1);
  endtask

  task automatic start(input int s, input logic [7:0] d);
    wait_ready(s);
    tx_data = d;
    set_v(s, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int s, input int drop_at, input bit scramble);
    int   i;
    logic e;
    i = 0;
    arb_seen = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk("pad", 32'(pad_of(s)), 32'(e));
      if (arb_of(s)) arb_seen = 1'b1;
      if (i == 0 && scramble) clkdiv = ~clkdiv;
      if (i == drop_at) begin
        @(posedge clk);
        #1;
        set_v(s, 1'b0);
      end
      i++;
    end
  endtask

  task automatic end_frame(input int s);
    chk("ready_last_cycle", 32'(rdy_of(s)), 32'd0);
    @(negedge clk);
    chk("ready_after_frame", 32'(rdy_of(s)), 32'd1);
    chk("arb_none", 32'(arb_seen), 32'd0);
  endtask

  initial begin
    logic seen;
    logic hi;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_arb", 32'(arb0), 32'd0);
    chk("rst_line", 32'(line0), 32'd1);
    chk("rst_pad", 32'(pad0), 32'd1);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_line1", 32'(line1), 32'd1);
    rst_n = 1'b1;

    // 0xA5, P=10, clkdiv disturbed mid-frame
    clkdiv = 8'd9;
    push_frame(8'hA5, 10, 1'b1);
    start(0, 8'hA5);
    v0 = 1'b0;
    drain(0, -1, 1'b1);
    clkdiv = 8'd9;
    end_frame(0);

    // arbitration lost on data bit 2 (value 1)
    push_frame(8'hA5, 10, 1'b1);
    start(0, 8'hA5);
    v0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 30) chk("arb_pre_pad", 32'(pad0), 32'(exp_q[i]));
      if (arb0) seen = 1'b1;
      if (i == 30) tb_low = 1'b1;
    end
    exp_q.delete();
    chk("arb_early", 32'(seen), 32'd0);
    @(negedge clk);
    chk("arb_pulse", 32'(arb0), 32'd1);
    chk("arb_ready", 32'(rdy0), 32'd1);
    tb_low = 1'b0;
    @(negedge clk);
    chk("arb_one_cycle", 32'(arb0), 32'd0);
    hi = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (pad0 !== 1'b1) hi = 1'b0;
    end
    chk("arb_released", 32'(hi), 32'd1);

    // clkdiv 0 and 3 both give P=4
    clkdiv = 8'd0;
    push_frame(8'h5A, 4, 1'b1);
    start(0, 8'h5A);
    v0 = 1'b0;
    drain(0, -1, 1'b0);
    end_frame(0);
    clkdiv = 8'd3;
    push_frame(8'hC3, 4, 1'b1);
    start(0, 8'hC3);
    v0 = 1'b0;
    drain(0, -1, 1'b0);
    end_frame(0);

    // LSB-first 0x01
    push_frame(8'h01, 4, 1'b0);
    start(1, 8'h01);
    v1 = 1'b0;
    drain(1, -1, 1'b0);
    end_frame(1);

    // async reset in data bit 4
    clkdiv = 8'd9;
    start(0, 8'hA5);
    v0 = 1'b0;
    repeat (55) @(negedge clk);
    chk("bit4_low", 32'(pad0), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pad", 32'(pad0), 32'd1);
    chk("async_ready", 32'(rdy0), 32'd1);
    chk("async_busy", 32'(busy0), 32'd0);
    chk("async_arb", 32'(arb0), 32'd0);
    chk("async_line", 32'(line0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    clkdiv = 8'd3;
    push_frame(8'h3C, 4, 1'b1);
    start(0, 8'h3C);
    v0 = 1'b0;
    drain(0, -1, 1'b0);
    end_frame(0);

    // back-to-back 0x00 then 0xFF, valid held
    push_frame(8'h00, 4, 1'b1);
    exp_q.push_back(1'b1);
    push_frame(8'hFF, 4, 1'b1);
    start(0, 8'h00);
    tx_data = 8'hFF;
    drain(0, 40, 1'b0);
    end_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/opendrain_serial_tx.md
Name: opendrain_serial_tx

Overview:
- Serial transmitter onto a single wired-AND line with an external or on-pad pullup. A shared "1" is the released pad; a "0" is the pad driven low.
- Frames each word as: start bit (low), W data bits, stop bit (released).
- Monitors the line during data bits and detects loss of arbitration when another device holds the line low.
- Sits between a simple valid/ready producer and a bidirectional open-drain pad, and instantiates the pad buffer itself.

Parameters:
- W, 8, data bits per frame.
- DIV_W, 8, width of the bit-period divider input.
- MSB_FIRST, 1, 1 = data MSB transmitted first; 0 = LSB first.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- clkdiv  input  DIV_W  bit period = max(clkdiv,3)+1 clk cycles; latched at frame acceptance.
- tx_data  input  W  word to send; captured on handshake.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  block idle and able to accept.
- busy  output  1  frame in progress (= !tx_ready).
- arb_lost  output  1  one-cycle pulse: arbitration lost, frame aborted.
- line  output  1  2-flop-synchronised pad level, non-inverted.
- pad  inout  1  open-drain pad; driven 0 or high-Z only, never driven 1.

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE and the pad is released immediately, with no clock needed.
  - tx_ready=1, busy=0, arb_lost=0, line=1, all counters 0.
- Pad primitive selection:
  - FPGA_ICE40: SB_IO with registered output-enable and pullup enabled.
  - FPGA_ECP5: bidirectional buffer with pullup.
  - Otherwise: generic tristate plus weak pull1 model.
  - Output data is tied 0; only the output enable is driven.
- Pad output enable is a register, asserted when the current transmitted bit is 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_ready=1.
  - tx_valid && tx_ready in cycle n captures tx_data and the effective period.
  - Pad driven low from cycle n+1; state START from n+1.
- Bit timing:
  - Divider counts 0..P-1, where P = max(clkdiv,3)+1.
  - The bit ends on count P-1, and the next bit starts on the following cycle.
- START: 1 bit period driven low, then DATA.
- DATA:
  - W bits, order per MSB_FIRST.
  - Bit counter runs 0..W-1.
- Arbitration check, data bits only:
  - On the last cycle of a bit whose value is 1, if line==0, arbitration is lost.
  - Next cycle: pad stays released, arb_lost=1 for exactly 1 cycle, state IDLE, tx_ready=1.
  - A tx_valid on that same cycle is accepted normally.
- No check is made during START or STOP. A low line during STOP is ignored.
- STOP:
  - 1 bit period released.
  - IDLE on the cycle after the stop bit's last cycle.
- Frame length:
  - (W+2)*P cycles from the first low-driven cycle.
  - tx_ready rises at cycle n+1+(W+2)*P.
- Back-to-back: with tx_valid held, the handshake occurs on the first IDLE cycle. There is a minimum of 1 released idle cycle between the stop bit and the next start bit.
- clkdiv changes mid-frame have no effect; the latched value is used until IDLE.
- tx_data changes after the handshake have no effect.
- line is always active, including in IDLE, for use by a companion receiver or by software.

Test Plan:
- W=8, MSB_FIRST=1, clkdiv=9, send 0xA5 with pad pulled up only:
  - Pad low for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then released stop for 10.
  - tx_ready returns high exactly 101 cycles after the handshake.
  - arb_lost stays 0.
- Same frame with the bench forcing pad low during data bit index 2 (value 1):
  - arb_lost pulses once, 1 cycle after that bit's last cycle.
  - Pad released thereafter, tx_ready=1; remaining bits are not sent.
- clkdiv=0 and clkdiv=3: both give a 4-cycle bit period, so a frame is 40 cycles.
- MSB_FIRST=0, send 0x01: start low, first data bit released, next 7 data bits low, stop released.
- Assert rst_n low in the middle of data bit 4 of a frame:
  - Pad released in the same cycle (asynchronous).
  - Outputs take reset values; after release, a new tx_valid starts a clean frame.
- tx_valid held high with 0x00 then 0xFF:
  - Second start bit begins after exactly 1 released idle cycle following the first stop bit.
  - No arb_lost on the 0xFF frame.
